axi_s_fifo: RTL and testbench
=============================

// Module: axi_s_fifo
// PURPOSE
//  Parametrised AXI4-Stream FIFO carrying the full sideband set (TDATA/TKEEP/TSTRB/TLAST/TID/TDEST/TUSER).
//  Two modes: cut-through (beat released as soon as stored) and packet mode (store-and-forward, release on TLAST).
//  Sits between axi_s_if slave and master ports as the elastic/packet buffer in DUT harnesses and VIP loopbacks.
// PARAMETERS
//  TDATA_WIDTH  8  data width in bits, multiple of 8; TKEEP/TSTRB width = TDATA_WIDTH/8
//  TID_WIDTH    1  TID width, >=1 (unused sideband: tie input 0, ignore output)
//  TDEST_WIDTH  1  TDEST width, >=1
//  TUSER_WIDTH  1  TUSER width, >=1
//  DEPTH        16 entries, power of 2, >=2
//  PACKET_MODE  0  0 = cut-through, 1 = store-and-forward
//  CW           $clog2(DEPTH)+1  derived; count width (localparam)
// PORTS
//  ACLK           in   1            clock; all logic on rising edge
//  ARESETn        in   1            reset, synchronous, active-low
//  S_TVALID       in   1            slave beat valid
//  S_TREADY       out  1            slave ready (= not full)
//  S_TDATA        in   TDATA_WIDTH  slave data
//  S_TKEEP        in   TDATA_WIDTH/8  slave byte keep
//  S_TSTRB        in   TDATA_WIDTH/8  slave byte strobe
//  S_TLAST        in   1            slave packet end
//  S_TID/S_TDEST/S_TUSER  in  TID_/TDEST_/TUSER_WIDTH  slave sideband
//  M_TVALID       out  1            master beat valid
//  M_TREADY       in   1            master ready
//  M_TDATA/M_TKEEP/M_TSTRB/M_TLAST/M_TID/M_TDEST/M_TUSER  out  as S_*  master beat
//  level          out  CW           entries stored
//  pkt_count      out  CW           complete packets stored (TLAST beats held)
//  oversize       out  1            sticky: packet-mode packet exceeded DEPTH
// BEHAVIOUR
//  Reset (ARESETn=0 at edge): pointers, level, pkt_count, oversize, fallback flag cleared; S_TREADY=0, M_TVALID=0
//   during reset; S_TREADY=1 first cycle after release. Reset mid-packet flushes all content; no beat is replayed.
//  Write: S_TVALID&S_TREADY at edge stores all S_* fields in one entry. Read: M_TVALID&M_TREADY pops head.
//  Pointers CW bits; full = MSBs differ & rest equal; empty = equal. Wrap at DEPTH, no gaps.
//  S_TREADY registered, = !full; simultaneous pop when full does not admit a write that cycle (1-cycle bubble).
//  Simultaneous push and pop when non-empty, non-full: level unchanged.
//  Latency: beat written at edge N visible on M_* after edge N (same cycle as level increments); M_* held stable
//   while M_TVALID & !M_TREADY (AXI-S stability rule); M_* data undefined-but-stable when M_TVALID=0.
//  Cut-through: M_TVALID = !empty.
//  Packet mode: pkt_count +1 on accepted TLAST write, -1 on TLAST read, both same edge -> unchanged.
//   M_TVALID = !empty & (pkt_count!=0 | fallback).
//   fallback set when full & pkt_count==0 (packet > DEPTH); also sets oversize (cleared only by reset).
//   fallback clears on the edge the TLAST beat of that packet is popped. While set, FIFO behaves cut-through.
//  No beat dropped, reordered or modified in any mode; TKEEP/TSTRB not interpreted.
//  level == write count - read count, never exceeds DEPTH; pkt_count <= level.
// STRUCTURE
//  axi_s_pkg: axi_s_beat_t packed struct (data, keep, strb, last, id, dest, user) built from parameters
//   via a parametrised class/typedef helper; fifo_ptr math function; mode enum {CUT_THROUGH, PACKET}.
//  Sub-module axi_s_fifo_mem: DEPTH x $bits(beat) storage, 1 write port, async read of head; inferred RAM/regs.
//  Top: pointer/level counters, packet counter, fallback flag, flag outputs.
// TESTING
//  1 DEPTH=4 cut-through: push 0x11,0x22,0x33,0x44 with M_TREADY=0 -> S_TREADY=0 after 4th, level=4;
//    M_TREADY=1 -> 0x11..0x44 out in order, level 0, S_TREADY back to 1.
//  2 Full + concurrent pop: level=4, S_TVALID=1, M_TREADY=1 -> one pop, no push that cycle, push next cycle.
//  3 Packet mode DEPTH=8: push 3 beats, TLAST on 3rd -> M_TVALID stays 0 until TLAST accepted, then
//    pkt_count=1, 3 beats out with TLAST on 3rd, pkt_count=0.
//  4 Packet mode DEPTH=4: 6-beat packet -> oversize=1 at full, beats drain cut-through, all 6 out intact,
//    next 2-beat packet held until its TLAST (fallback cleared).
//  5 Sideband: TID=1,TDEST=2,TUSER=1,TKEEP=0x1,TSTRB=0x1 beats -> identical on M_*; M stable under backpressure.
//  6 ARESETn=0 for 1 cycle with level=3, pkt_count=1 -> level=0, pkt_count=0, M_TVALID=0, oversize=0.

Source files
------------

// File: rtl/axi_s_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_s_fifo_pkg
//  Description : Shared types and helpers for the AXI4-Stream FIFO: operating
//                mode encoding, beat width calculation and pointer increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_s_fifo_pkg;

  // Release policy of the FIFO.
  typedef enum logic {
    CUT_THROUGH = 1'b0,
    PACKET      = 1'b1
  } fifo_mode_e;

  // Width of one stored beat: data, keep, strb, last, id, dest, user.
  function automatic int unsigned beat_bits(input int unsigned dw,
                                            input int unsigned iw,
                                            input int unsigned dstw,
                                            input int unsigned uw);
    return dw + 2 * (dw / 8) + 1 + iw + dstw + uw;
  endfunction

  // Increment a pointer of cw bits, wrapping naturally at 2**cw.
  // The extra MSB above the address bits distinguishes full from empty.
  function automatic logic [31:0] fifo_ptr_inc(input logic [31:0]   ptr,
                                               input int unsigned   cw);
    logic [31:0] mask;
    mask = (32'd1 << cw) - 32'd1;
    return (ptr + 32'd1) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_s_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_s_fifo_mem
//  Description : DEPTH x WIDTH beat storage with one synchronous write port
//                and an asynchronous read of the head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_s_fifo_mem
  import axi_s_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store an accepted beat; contents need no reset since pointers gate use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/axi_s_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi_s_fifo
//  Description : AXI4-Stream FIFO carrying the full sideband set, with
//                cut-through or store-and-forward (packet) release. Oversize
//                packets in packet mode fall back to cut-through until their
//                TLAST beat leaves.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_s_fifo
  import axi_s_fifo_pkg::*;
#(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        S_TVALID,
  output logic                        S_TREADY,
  input  logic [TDATA_WIDTH-1:0]      S_TDATA,
  input  logic [TDATA_WIDTH/8-1:0]    S_TKEEP,
  input  logic [TDATA_WIDTH/8-1:0]    S_TSTRB,
  input  logic                        S_TLAST,
  input  logic [TID_WIDTH-1:0]        S_TID,
  input  logic [TDEST_WIDTH-1:0]      S_TDEST,
  input  logic [TUSER_WIDTH-1:0]      S_TUSER,
  output logic                        M_TVALID,
  input  logic                        M_TREADY,
  output logic [TDATA_WIDTH-1:0]      M_TDATA,
  output logic [TDATA_WIDTH/8-1:0]    M_TKEEP,
  output logic [TDATA_WIDTH/8-1:0]    M_TSTRB,
  output logic                        M_TLAST,
  output logic [TID_WIDTH-1:0]        M_TID,
  output logic [TDEST_WIDTH-1:0]      M_TDEST,
  output logic [TUSER_WIDTH-1:0]      M_TUSER,
  output logic [$clog2(DEPTH):0]      level,
  output logic [$clog2(DEPTH):0]      pkt_count,
  output logic                        oversize
);

  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam int          AW     = CW - 1;
  localparam int          KW     = TDATA_WIDTH / 8;
  localparam int unsigned BEAT_W = beat_bits(TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);
  localparam fifo_mode_e  MODE   = (PACKET_MODE != 0) ? PACKET : CUT_THROUGH;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic [KW-1:0]          keep;
    logic [KW-1:0]          strb;
    logic                   last;
    logic [TID_WIDTH-1:0]   id;
    logic [TDEST_WIDTH-1:0] dest;
    logic [TUSER_WIDTH-1:0] user;
  } beat_t;

  beat_t             wr_beat;
  beat_t             rd_beat;
  logic [BEAT_W-1:0] rd_word;

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] wr_ptr_n;
  logic [CW-1:0] rd_ptr_n;
  logic [CW-1:0] pkt_cnt;
  logic          s_ready;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic          full_n;
  logic          last_in;
  logic          last_out;
  logic          release_ok;
  logic          oversize_flag;

  assign wr_beat = '{data: S_TDATA, keep: S_TKEEP, strb: S_TSTRB, last: S_TLAST,
                     id: S_TID, dest: S_TDEST, user: S_TUSER};
  assign rd_beat = beat_t'(rd_word);

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[CW-1] != rd_ptr[CW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = S_TVALID & s_ready;
  assign pop      = M_TVALID & M_TREADY;
  assign last_in  = push & S_TLAST;
  assign last_out = pop & rd_beat.last;

  // Next pointer values; used both for the pointer update and for the
  // registered ready, so a pop while full only re-opens ready next cycle.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (push) begin
      wr_ptr_n = CW'(fifo_ptr_inc(32'(wr_ptr), CW));
    end
    if (pop) begin
      rd_ptr_n = CW'(fifo_ptr_inc(32'(rd_ptr), CW));
    end
    full_n = (wr_ptr_n[CW-1] != rd_ptr_n[CW-1]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
  end

  // Pointer registers and registered slave ready.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      s_ready <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      s_ready <= !full_n;
    end
  end

  // Count of TLAST beats held; simultaneous in/out leaves it unchanged.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      pkt_cnt <= '0;
    end else begin
      case ({last_in, last_out})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  generate
    if (MODE == PACKET) begin : g_packet
      logic fallback;

      // A full FIFO with no complete packet can never release one, so switch
      // to cut-through until that oversize packet's TLAST has been popped.
      always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
          fallback      <= 1'b0;
          oversize_flag <= 1'b0;
        end else if (full && (pkt_cnt == '0)) begin
          fallback      <= 1'b1;
          oversize_flag <= 1'b1;
        end else if (fallback && last_out) begin
          fallback      <= 1'b0;
        end
      end

      assign release_ok = (pkt_cnt != '0) | fallback;
    end else begin : g_cut_through
      assign release_ok    = 1'b1;
      assign oversize_flag = 1'b0;
    end
  endgenerate

  axi_s_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (BEAT_W)
  ) u_mem (
    .clk     (ACLK),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_beat),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_word)
  );

  assign S_TREADY  = s_ready;
  assign M_TVALID  = !empty & release_ok;
  assign M_TDATA   = rd_beat.data;
  assign M_TKEEP   = rd_beat.keep;
  assign M_TSTRB   = rd_beat.strb;
  assign M_TLAST   = rd_beat.last;
  assign M_TID     = rd_beat.id;
  assign M_TDEST   = rd_beat.dest;
  assign M_TUSER   = rd_beat.user;
  assign level     = wr_ptr - rd_ptr;
  assign pkt_count = pkt_cnt;
  assign oversize  = oversize_flag;

endmodule
`default_nettype wire

// File: tb/tb_axi_s_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_s_fifo
//  Description : Directed bench for axi_s_fifo. Three instances share the
//                slave/master stimulus: A = DEPTH 4 cut-through,
//                B = DEPTH 8 packet mode, C = DEPTH 4 packet mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_s_fifo;

  logic       clk;
  logic       aresetn;
  logic       s_tvalid;
  logic [7:0] s_tdata;
  logic       s_tkeep;
  logic       s_tstrb;
  logic       s_tlast;
  logic       s_tid;
  logic [1:0] s_tdest;
  logic       s_tuser;
  logic       m_tready;

  logic       sr   [3];
  logic       mv   [3];
  logic [7:0] md   [3];
  logic       mk   [3];
  logic       ms   [3];
  logic       ml   [3];
  logic       mid  [3];
  logic [1:0] mdst [3];
  logic       mu   [3];
  logic       ovs  [3];
  logic [2:0] lvl_a, pc_a, lvl_c, pc_c;
  logic [3:0] lvl_b, pc_b;

  int n_cmp  = 0;
  int n_miss = 0;

  axi_s_fifo #(.TDATA_WIDTH(8), .TID_WIDTH(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1),
               .DEPTH(4), .PACKET_MODE(0)) u_a (
    .ACLK(clk), .ARESETn(aresetn), .S_TVALID(s_tvalid), .S_TREADY(sr[0]),
    .S_TDATA(s_tdata), .S_TKEEP(s_tkeep), .S_TSTRB(s_tstrb), .S_TLAST(s_tlast),
    .S_TID(s_tid), .S_TDEST(s_tdest), .S_TUSER(s_tuser),
    .M_TVALID(mv[0]), .M_TREADY(m_tready), .M_TDATA(md[0]), .M_TKEEP(mk[0]),
    .M_TSTRB(ms[0]), .M_TLAST(ml[0]), .M_TID(mid[0]), .M_TDEST(mdst[0]),
    .M_TUSER(mu[0]), .level(lvl_a), .pkt_count(pc_a), .oversize(ovs[0]));

  axi_s_fifo #(.TDATA_WIDTH(8), .TID_WIDTH(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1),
               .DEPTH(8), .PACKET_MODE(1)) u_b (
    .ACLK(clk), .ARESETn(aresetn), .S_TVALID(s_tvalid), .S_TREADY(sr[1]),
    .S_TDATA(s_tdata), .S_TKEEP(s_tkeep), .S_TSTRB(s_tstrb), .S_TLAST(s_tlast),
    .S_TID(s_tid), .S_TDEST(s_tdest), .S_TUSER(s_tuser),
    .M_TVALID(mv[1]), .M_TREADY(m_tready), .M_TDATA(md[1]), .M_TKEEP(mk[1]),
    .M_TSTRB(ms[1]), .M_TLAST(ml[1]), .M_TID(mid[1]), .M_TDEST(mdst[1]),
    .M_TUSER(mu[1]), .level(lvl_b), .pkt_count(pc_b), .oversize(ovs[1]));

  axi_s_fifo #(.TDATA_WIDTH(8), .TID_WIDTH(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1),
               .DEPTH(4), .PACKET_MODE(1)) u_c (
    .ACLK(clk), .ARESETn(aresetn), .S_TVALID(s_tvalid), .S_TREADY(sr[2]),
    .S_TDATA(s_tdata), .S_TKEEP(s_tkeep), .S_TSTRB(s_tstrb), .S_TLAST(s_tlast),
    .S_TID(s_tid), .S_TDEST(s_tdest), .S_TUSER(s_tuser),
    .M_TVALID(mv[2]), .M_TREADY(m_tready), .M_TDATA(md[2]), .M_TKEEP(mk[2]),
    .M_TSTRB(ms[2]), .M_TLAST(ml[2]), .M_TID(mid[2]), .M_TDEST(mdst[2]),
    .M_TUSER(mu[2]), .level(lvl_c), .pkt_count(pc_c), .oversize(ovs[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    int         dut;
    logic       sv;
    logic [7:0] sd;
    logic       sl;
    logic       mr;
    logic       esr;
    logic       emv;
    logic [7:0] emd;
    logic       eml;
    int         elvl;
    int         epc;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] lvl_of(input int k);
    case (k)
      0:       return 32'(lvl_a);
      1:       return 32'(lvl_b);
      default: return 32'(lvl_c);
    endcase
  endfunction

  function automatic logic [31:0] pc_of(input int k);
    case (k)
      0:       return 32'(pc_a);
      1:       return 32'(pc_b);
      default: return 32'(pc_c);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addv(input bit rst, input int dut, input logic sv, input logic [7:0] sd,
                      input logic sl, input logic mr, input logic esr, input logic emv,
                      input logic [7:0] emd, input logic eml, input int elvl, input int epc);
    vec_t v;
    v = '{rst, dut, sv, sd, sl, mr, esr, emv, emd, eml, elvl, epc};
    vq.push_back(v);
  endtask

  // Reset for two edges; ready/valid must be low while held, ready high after release.
  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_sready_low", 32'(sr[0]), 32'd0);
    chk("rst_mvalid_low", 32'(mv[0]), 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_sready_after", 32'(sr[0]), 32'd1);
    chk("rst_level_zero", lvl_of(0), 32'd0);
  endtask

  task automatic drive(input logic sv, input logic [7:0] sd, input logic sl, input logic mr);
    s_tvalid = sv;
    s_tdata  = sd;
    s_tlast  = sl;
    m_tready = mr;
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] send_q[$];
    int         got;
    int         si;

    aresetn  = 1'b0;
    s_tkeep  = 1'b1;
    s_tstrb  = 1'b1;
    s_tid    = 1'b0;
    s_tdest  = 2'd0;
    s_tuser  = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // A: fill to full, full+concurrent pop bubble, drain in order.
    //    rst dut sv  sd     sl  mr   esr emv emd    eml lvl pc
    addv(1, 0, 1, 8'h11, 0, 0,   1, 0, 8'h00, 0, 0, 0);
    addv(0, 0, 1, 8'h22, 0, 0,   1, 1, 8'h11, 0, 1, 0);
    addv(0, 0, 1, 8'h33, 0, 0,   1, 1, 8'h11, 0, 2, 0);
    addv(0, 0, 1, 8'h44, 1, 0,   1, 1, 8'h11, 0, 3, 0);
    addv(0, 0, 1, 8'h55, 0, 0,   0, 1, 8'h11, 0, 4, 1);
    addv(0, 0, 1, 8'h55, 0, 1,   0, 1, 8'h11, 0, 4, 1);
    addv(0, 0, 1, 8'h55, 0, 1,   1, 1, 8'h22, 0, 3, 1);
    addv(0, 0, 0, 8'h00, 0, 1,   1, 1, 8'h33, 0, 3, 1);
    addv(0, 0, 0, 8'h00, 0, 1,   1, 1, 8'h44, 1, 2, 1);
    addv(0, 0, 0, 8'h00, 0, 1,   1, 1, 8'h55, 0, 1, 0);
    addv(0, 0, 0, 8'h00, 0, 0,   1, 0, 8'h00, 0, 0, 0);
    // B: 3-beat packet held until TLAST accepted, then released in order.
    addv(1, 1, 1, 8'hA1, 0, 1,   1, 0, 8'h00, 0, 0, 0);
    addv(0, 1, 1, 8'hA2, 0, 1,   1, 0, 8'h00, 0, 1, 0);
    addv(0, 1, 1, 8'hA3, 1, 1,   1, 0, 8'h00, 0, 2, 0);
    addv(0, 1, 0, 8'h00, 0, 0,   1, 1, 8'hA1, 0, 3, 1);
    addv(0, 1, 0, 8'h00, 0, 1,   1, 1, 8'hA1, 0, 3, 1);
    addv(0, 1, 0, 8'h00, 0, 1,   1, 1, 8'hA2, 0, 2, 1);
    addv(0, 1, 0, 8'h00, 0, 1,   1, 1, 8'hA3, 1, 1, 1);
    addv(0, 1, 0, 8'h00, 0, 0,   1, 0, 8'h00, 0, 0, 0);

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      @(negedge clk);
      drive(vq[i].sv, vq[i].sd, vq[i].sl, vq[i].mr);
      #1;
      chk($sformatf("v%0d_sready", i), 32'(sr[vq[i].dut]), 32'(vq[i].esr));
      chk($sformatf("v%0d_mvalid", i), 32'(mv[vq[i].dut]), 32'(vq[i].emv));
      chk($sformatf("v%0d_level", i), lvl_of(vq[i].dut), 32'(vq[i].elvl));
      chk($sformatf("v%0d_pkt_count", i), pc_of(vq[i].dut), 32'(vq[i].epc));
      if (vq[i].emv) begin
        chk($sformatf("v%0d_tdata", i), 32'(md[vq[i].dut]), 32'(vq[i].emd));
        chk($sformatf("v%0d_tlast", i), 32'(ml[vq[i].dut]), 32'(vq[i].eml));
      end
    end

    // A: sideband passes unchanged and stays stable under backpressure.
    do_reset();
    @(negedge clk);
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    s_tid = 1'b1; s_tdest = 2'd2; s_tuser = 1'b1; s_tkeep = 1'b1; s_tstrb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, 8'hC3, 1'b0, (k == 2) ? 1'b1 : 1'b0);
      s_tid = 1'b0; s_tdest = 2'd1; s_tuser = 1'b0; s_tkeep = 1'b0; s_tstrb = 1'b0;
      #1;
      chk($sformatf("sb%0d_mvalid", k), 32'(mv[0]), 32'd1);
      chk($sformatf("sb%0d_tdata", k), 32'(md[0]), 32'h5A);
      chk($sformatf("sb%0d_tlast", k), 32'(ml[0]), 32'd1);
      chk($sformatf("sb%0d_tid", k), 32'(mid[0]), 32'd1);
      chk($sformatf("sb%0d_tdest", k), 32'(mdst[0]), 32'd2);
      chk($sformatf("sb%0d_tuser", k), 32'(mu[0]), 32'd1);
      chk($sformatf("sb%0d_tkeep", k), 32'(mk[0]), 32'd1);
      chk($sformatf("sb%0d_tstrb", k), 32'(ms[0]), 32'd1);
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("sb_popped_mvalid", 32'(mv[0]), 32'd0);
    s_tkeep = 1'b1; s_tstrb = 1'b1; s_tdest = 2'd0;

    // C: 6-beat packet overflows DEPTH 4 and falls back to cut-through.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 8'hB1 + 8'(k), 1'b0, 1'b0);
      #1;
      chk($sformatf("ov_push%0d_sready", k), 32'(sr[2]), 32'd1);
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("ov_full_level", lvl_of(2), 32'd4);
    chk("ov_full_sready", 32'(sr[2]), 32'd0);
    chk("ov_full_mvalid", 32'(mv[2]), 32'd0);
    chk("ov_before_flag", 32'(ovs[2]), 32'd0);
    @(negedge clk);
    #1;
    chk("ov_flag_set", 32'(ovs[2]), 32'd1);
    chk("ov_fallback_mvalid", 32'(mv[2]), 32'd1);
    chk("ov_fallback_head", 32'(md[2]), 32'hB1);

    exp_q  = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6};
    send_q = '{8'hB5, 8'hB6};
    got = 0;
    si  = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      if (si < 2) drive(1'b1, send_q[si], (si == 1) ? 1'b1 : 1'b0, 1'b1);
      else        drive(1'b0, 8'h00, 1'b0, 1'b1);
      #1;
      if (mv[2]) begin
        chk($sformatf("ov_out%0d_tdata", got), 32'(md[2]), 32'(exp_q[got]));
        chk($sformatf("ov_out%0d_tlast", got), 32'(ml[2]), (got == 5) ? 32'd1 : 32'd0);
        got++;
      end
      if (s_tvalid && sr[2]) si++;
    end
    chk("ov_beats_out", 32'(got), 32'd6);

    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("ov_drained_level", lvl_of(2), 32'd0);
    chk("ov_drained_pkt", pc_of(2), 32'd0);
    chk("ov_sticky", 32'(ovs[2]), 32'd1);

    // C: next 2-beat packet must be held again (fallback cleared).
    @(negedge clk);
    drive(1'b1, 8'hC1, 1'b0, 1'b1);
    #1;
    chk("pk2_c1_sready", 32'(sr[2]), 32'd1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    chk("pk2_hold0_mvalid", 32'(mv[2]), 32'd0);
    chk("pk2_hold0_level", lvl_of(2), 32'd1);
    @(negedge clk);
    #1;
    chk("pk2_hold1_mvalid", 32'(mv[2]), 32'd0);
    @(negedge clk);
    drive(1'b1, 8'hC2, 1'b1, 1'b1);
    #1;
    chk("pk2_hold2_mvalid", 32'(mv[2]), 32'd0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("pk2_rel_mvalid", 32'(mv[2]), 32'd1);
    chk("pk2_rel_tdata", 32'(md[2]), 32'hC1);
    chk("pk2_rel_pkt", pc_of(2), 32'd1);
    chk("pk2_rel_level", lvl_of(2), 32'd2);
    @(negedge clk);
    m_tready = 1'b1;
    #1;
    chk("pk2_out0_tdata", 32'(md[2]), 32'hC1);
    chk("pk2_out0_tlast", 32'(ml[2]), 32'd0);
    @(negedge clk);
    #1;
    chk("pk2_out1_mvalid", 32'(mv[2]), 32'd1);
    chk("pk2_out1_tdata", 32'(md[2]), 32'hC2);
    chk("pk2_out1_tlast", 32'(ml[2]), 32'd1);
    @(negedge clk);
    m_tready = 1'b0;
    #1;
    chk("pk2_done_mvalid", 32'(mv[2]), 32'd0);
    chk("pk2_done_level", lvl_of(2), 32'd0);
    chk("pk2_done_pkt", pc_of(2), 32'd0);

    // C: one-cycle reset mid-content flushes everything incl. oversize.
    @(negedge clk); drive(1'b1, 8'hD1, 1'b1, 1'b0);
    @(negedge clk); drive(1'b1, 8'hD2, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 8'hD3, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("mr_pre_level", lvl_of(2), 32'd3);
    chk("mr_pre_pkt", pc_of(2), 32'd1);
    chk("mr_pre_oversize", 32'(ovs[2]), 32'd1);
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    chk("mr_level", lvl_of(2), 32'd0);
    chk("mr_pkt", pc_of(2), 32'd0);
    chk("mr_mvalid", 32'(mv[2]), 32'd0);
    chk("mr_oversize", 32'(ovs[2]), 32'd0);
    chk("mr_sready_low", 32'(sr[2]), 32'd0);
    @(negedge clk);
    #1;
    chk("mr_sready_back", 32'(sr[2]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
